// File: rtl/i_decode.sv
// MIPS ID stage: control decode, 32x32 register file with write-through
// bypass, sign extension, and the ID/EX pipeline latch.
module i_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] npc,
  input  logic [4:0]  mem_wb_writereg,
  input  logic [31:0] mem_wb_writedata,
  input  logic        regwrite,
  output logic [1:0]  wb_out,
  output logic [2:0]  m_out,
  output logic [3:0]  ex_out,
  output logic [31:0] npc_out,
  output logic [31:0] reg_rs_out,
  output logic [31:0] reg_rt_out,
  output logic [31:0] sign_ext_out,
  output logic [4:0]  instr_20_16_out,
  output logic [4:0]  instr_15_11_out
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign imm    = instr[15:0];

  logic [3:0]  ex_d;
  logic [2:0]  m_d;
  logic [1:0]  wb_d;
  logic [31:0] sext_d;
  logic [31:0] rs_d, rt_d;
  logic        wr_en;

  // Opcode to {ex, m, wb} control groups; unknown opcodes become a NOP.
  always_comb begin
    ex_d = 4'b0000;
    m_d  = 3'b000;
    wb_d = 2'b00;
    case (opcode)
      OP_RTYPE: begin ex_d = 4'b1100; m_d = 3'b000; wb_d = 2'b10; end
      OP_LW:    begin ex_d = 4'b0001; m_d = 3'b010; wb_d = 2'b11; end
      OP_SW:    begin ex_d = 4'b0001; m_d = 3'b001; wb_d = 2'b00; end
      OP_BEQ:   begin ex_d = 4'b0010; m_d = 3'b100; wb_d = 2'b00; end
      default:  begin ex_d = 4'b0000; m_d = 3'b000; wb_d = 2'b00; end
    endcase
  end

  assign sext_d = {{16{imm[15]}}, imm};

  // Register 0 is never written, so a write to it is simply dropped.
  assign wr_en = regwrite && (mem_wb_writereg != 5'd0);

  logic [31:0] regs [32];

  // Register file write port; reset seeds each entry with its own index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
    end else if (wr_en) begin
      regs[mem_wb_writereg] <= mem_wb_writedata;
    end
  end

  // Read ports: r0 is hard zero, and a same-cycle write-back bypasses the array.
  always_comb begin
    rs_d = regs[rs];
    rt_d = regs[rt];
    if (rs == 5'd0)                          rs_d = 32'd0;
    else if (wr_en && mem_wb_writereg == rs) rs_d = mem_wb_writedata;
    if (rt == 5'd0)                          rt_d = 32'd0;
    else if (wr_en && mem_wb_writereg == rt) rt_d = mem_wb_writedata;
  end

  // ID/EX latch loads every cycle; no stall or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_out          <= '0;
      m_out           <= '0;
      ex_out          <= '0;
      npc_out         <= '0;
      reg_rs_out      <= '0;
      reg_rt_out      <= '0;
      sign_ext_out    <= '0;
      instr_20_16_out <= '0;
      instr_15_11_out <= '0;
    end else begin
      wb_out          <= wb_d;
      m_out           <= m_d;
      ex_out          <= ex_d;
      npc_out         <= npc;
      reg_rs_out      <= rs_d;
      reg_rt_out      <= rt_d;
      sign_ext_out    <= sext_d;
      instr_20_16_out <= rt;
      instr_15_11_out <= rd;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// Directed, table-driven bench for the i_decode ID stage.
module tb_i_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, npc, mem_wb_writedata;
  logic [4:0]  mem_wb_writereg;
  logic        regwrite;
  logic [1:0]  wb_out;
  logic [2:0]  m_out;
  logic [3:0]  ex_out;
  logic [31:0] npc_out, reg_rs_out, reg_rt_out, sign_ext_out;
  logic [4:0]  instr_20_16_out, instr_15_11_out;

  int n_cmp = 0;
  int n_bad = 0;

  i_decode dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .npc(npc),
    .mem_wb_writereg(mem_wb_writereg), .mem_wb_writedata(mem_wb_writedata),
    .regwrite(regwrite), .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out),
    .npc_out(npc_out), .reg_rs_out(reg_rs_out), .reg_rt_out(reg_rt_out),
    .sign_ext_out(sign_ext_out), .instr_20_16_out(instr_20_16_out),
    .instr_15_11_out(instr_15_11_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [3:0]  ex;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] se;
    logic [4:0]  i20;
    logic [4:0]  i15;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " ex"},  32'(ex_out), 32'(v.ex));
    chk({tag, " m"},   32'(m_out),  32'(v.m));
    chk({tag, " wb"},  32'(wb_out), 32'(v.wb));
    chk({tag, " npc"}, npc_out,     v.npc);
    chk({tag, " rs"},  reg_rs_out,  v.rs);
    chk({tag, " rt"},  reg_rt_out,  v.rt);
    chk({tag, " se"},  sign_ext_out, v.se);
    chk({tag, " i20"}, 32'(instr_20_16_out), 32'(v.i20));
    chk({tag, " i15"}, 32'(instr_15_11_out), 32'(v.i15));
  endtask

  vec_t tbl[14];
  vec_t zero_v;

  initial begin
    //        instr          npc     rw wreg wdata          ex    m     wb   rs            rt            se            i20 i15
    tbl[0]  = '{32'h002300AA, 32'h04, 0, 0, 32'h0,        4'hC, 3'd0, 2'd2, 32'd1,        32'd3,        32'h000000AA, 3,  0};
    tbl[1]  = '{32'h10654321, 32'h08, 0, 0, 32'h0,        4'h2, 3'd4, 2'd0, 32'd3,        32'd5,        32'h00004321, 5,  8};
    tbl[2]  = '{32'h13012345, 32'h0C, 0, 0, 32'h0,        4'h2, 3'd4, 2'd0, 32'd24,       32'd1,        32'h00002345, 1,  4};
    tbl[3]  = '{32'h8C123456, 32'h10, 0, 0, 32'h0,        4'h1, 3'd2, 2'd3, 32'd0,        32'd18,       32'h00003456, 18, 6};
    tbl[4]  = '{32'h8F123456, 32'h14, 0, 0, 32'h0,        4'h1, 3'd2, 2'd3, 32'd24,       32'd18,       32'h00003456, 18, 6};
    tbl[5]  = '{32'hAD654321, 32'h18, 0, 0, 32'h0,        4'h1, 3'd1, 2'd0, 32'd11,       32'd5,        32'h00004321, 5,  8};
    tbl[6]  = '{32'hAC654321, 32'h1C, 0, 0, 32'h0,        4'h1, 3'd1, 2'd0, 32'd3,        32'd5,        32'h00004321, 5,  8};
    // write-back to r3 seen via rs bypass, then from the array
    tbl[7]  = '{32'h10654321, 32'h20, 1, 3, 32'hDEADBEEF, 4'h2, 3'd4, 2'd0, 32'hDEADBEEF, 32'd5,        32'h00004321, 5,  8};
    tbl[8]  = '{32'h002300AA, 32'h24, 0, 0, 32'h0,        4'hC, 3'd0, 2'd2, 32'd1,        32'hDEADBEEF, 32'h000000AA, 3,  0};
    // rt-side bypass on r5
    tbl[9]  = '{32'hAD654321, 32'h28, 1, 5, 32'hCAFEF00D, 4'h1, 3'd1, 2'd0, 32'd11,       32'hCAFEF00D, 32'h00004321, 5,  8};
    // write to r0 ignored (no bypass, no store)
    tbl[10] = '{32'h00000000, 32'h2C, 1, 0, 32'h00001234, 4'hC, 3'd0, 2'd2, 32'd0,        32'd0,        32'h00000000, 0,  0};
    tbl[11] = '{32'h00000000, 32'h30, 0, 0, 32'h0,        4'hC, 3'd0, 2'd2, 32'd0,        32'd0,        32'h00000000, 0,  0};
    // negative immediate
    tbl[12] = '{32'h8C018000, 32'h34, 0, 0, 32'h0,        4'h1, 3'd2, 2'd3, 32'd0,        32'd1,        32'hFFFF8000, 1,  16};
    // unknown opcode 0x3F
    tbl[13] = '{32'hFC000000, 32'h38, 0, 0, 32'h0,        4'h0, 3'd0, 2'd0, 32'd0,        32'd0,        32'h00000000, 0,  0};
    zero_v  = '{32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 3'd0, 2'd0, 32'd0, 32'd0, 32'h0, 0, 0};

    rst_n = 1'b0; instr = 32'h002300AA; npc = 32'h04;
    regwrite = 1'b0; mem_wb_writereg = 5'd0; mem_wb_writedata = 32'h0;
    repeat (3) @(posedge clk);
    #1 chk_all("reset", zero_v);

    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i != 0) @(negedge clk);
      instr = tbl[i].instr; npc = tbl[i].npc;
      regwrite = tbl[i].rw; mem_wb_writereg = tbl[i].wreg; mem_wb_writedata = tbl[i].wdata;
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), tbl[i]);
    end

    // Mid-operation reset: outputs clear immediately, pending write to r3 lost,
    // and the array is re-seeded so r3 reads 3 again.
    @(negedge clk);
    instr = 32'h10654321; npc = 32'h40;
    regwrite = 1'b1; mem_wb_writereg = 5'd3; mem_wb_writedata = 32'h55555555;
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", zero_v);
    @(posedge clk);
    #1 chk_all("rst_hold", zero_v);
    @(negedge clk);
    rst_n = 1'b1; regwrite = 1'b0; mem_wb_writereg = 5'd0;
    @(posedge clk);
    #1 begin
      chk("post_rst rs", reg_rs_out, 32'd3);
      chk("post_rst rt", reg_rt_out, 32'd5);
      chk("post_rst npc", npc_out, 32'h40);
      chk("post_rst ex", 32'(ex_out), 32'h2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i_decode.md
# i_decode

Instruction-decode (ID) stage of the 5-stage MIPS pipeline. Sits between the IF/ID latch and the execute stage. It decodes the opcode into WB/M/EX control groups, reads rs/rt from a 32×32 register file, sign-extends the 16-bit immediate, and latches all results into the ID/EX pipeline register. It also accepts the register write-back from the MEM/WB stage.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- instr  in  32  instruction from IF/ID
- npc  in  32  next PC (PC+4) from IF/ID
- mem_wb_writereg  in  5  write-back destination register
- mem_wb_writedata  in  32  write-back data
- regwrite  in  1  write-back enable
- wb_out  out  2  {RegWrite, MemtoReg}
- m_out  out  3  {Branch, MemRead, MemWrite}
- ex_out  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- npc_out  out  32  latched npc
- reg_rs_out  out  32  latched rs read data
- reg_rt_out  out  32  latched rt read data
- sign_ext_out  out  32  latched sign-extended immediate
- instr_20_16_out  out  5  latched instr[20:16]
- instr_15_11_out  out  5  latched instr[15:11]

Clocking is fixed: one clock, and reset is asynchronous and active-low.

## Operation
- Fields:
  - opcode = instr[31:26]
  - rs = instr[25:21]
  - rt = instr[20:16]
  - rd = instr[15:11]
  - imm = instr[15:0]
- Control decode, combinational, given as {ex | m | wb}:
  - R-type (000000): 1100 | 000 | 10
  - lw (100011): 0001 | 010 | 11
  - sw (101011): 0001 | 001 | 00
  - beq (000100): 0010 | 100 | 00
  - Any other opcode: 0000 | 000 | 00. This acts as a NOP, so no side effects downstream.
- Sign extension: {{16{imm[15]}}, imm}.
- Register file: 32 entries of 32 bits, with two combinational read ports (rs, rt) and one write port.
  - Register 0 always reads 0.
  - Writes to register 0 are ignored.
- Write: on the rising clk edge, when regwrite=1 and mem_wb_writereg≠0, reg[mem_wb_writereg] ← mem_wb_writedata.
- Write-through bypass: if regwrite=1, mem_wb_writereg≠0, and mem_wb_writereg equals rs (or rt), that read port returns mem_wb_writedata instead of the stored value. A same-cycle write is therefore visible in the value latched into ID/EX.
- ID/EX latch: on each rising edge, all outputs load from the decode, read, and sign-extend results for the current instr/npc.
- No stall or flush inputs; the latch loads every cycle.

## Timing
- Reset (rst_n=0, asynchronous):
  - All outputs go to 0 immediately.
  - Register file entries initialize to reg[i] = i (reg0 = 0).
  - The state holds while rst_n=0. Asserting reset mid-operation discards any in-flight latch contents and any pending write in that cycle.
- Release: the first rising edge with rst_n=1 latches normally.
- Latency:
  - Instruction applied before edge N appears on the outputs after edge N (1 cycle).
  - Outputs are stable for the full following cycle.
- Simultaneous write and read of the same register: the bypassed (new) data is latched, and the array is updated at the same edge.
- An undefined instr (X) yields undefined outputs. Nothing beyond the latch is affected.

## Test plan
- Reset: hold rst_n=0 with clocking → all outputs 0. After release, instr=0x002300AA captured → reg_rs_out=1, reg_rt_out=3, ex=1100, m=000, wb=10, sign_ext_out=0x000000AA, instr_20_16_out=3, instr_15_11_out=0, npc_out=npc.
- beq 0x10654321 → ex=0010, m=100, wb=00, rs_out=3, rt_out=5, sign_ext_out=0x00004321. Then beq 0x13012345 → rs_out=24, rt_out=1.
- lw 0x8C123456 → ex=0001, m=010, wb=11, rs_out=0, rt_out=18, instr_20_16_out=18, sign_ext_out=0x00003456. Then lw 0x8F123456 → rs_out=24.
- sw 0xAD654321 → ex=0001, m=001, wb=00, rs_out=11, rt_out=5. Then sw 0xAC654321 → rs_out=3.
- Write-back:
  - regwrite=1, writereg=3, writedata=0xDEADBEEF while instr=0x10654321 → rs_out=0xDEADBEEF at that edge (bypass). The next read of reg 3 also returns 0xDEADBEEF.
  - writereg=0 with data 0x1234 → reg 0 still reads 0.
- Negative immediate and unknown opcode: instr=0x8C01_8000 → sign_ext_out=0xFFFF8000. Opcode 0x3F → ex/m/wb all 0.
